// File: rtl/mux_serializer_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_ser_pkg                                                          |
// | Shared widths, FSM state type and select start helper.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mux_ser_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    function automatic logic [SEL_W-1:0] sel_start(input logic msb_first);
        return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_serializer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_serializer_ctrl_if                                               |
// | Word handshake, bit tick, mux connection and serial output bundle.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mux_serializer_ctrl_if;
    import mux_ser_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              bit_tick;
    logic [WORD_W-1:0] mux_data;
    logic [SEL_W-1:0]  sel;
    logic              mux_f;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_first;
    logic              ser_last;

    modport master (
        output in_valid, in_data, bit_tick, mux_f,
        input  in_ready, mux_data, sel, ser_out, ser_valid, ser_first, ser_last
    );

    modport slave (
        input  in_valid, in_data, bit_tick, mux_f,
        output in_ready, mux_data, sel, ser_out, ser_valid, ser_first, ser_last
    );
endinterface
`default_nettype wire

// File: rtl/mux_serializer_ctrl_sel_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sel_stepper                                                          |
// | Loadable up/down counter with enable and end-of-range flag.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sel_stepper #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    input  wire logic         i_en,
    input  wire logic         i_down,
    output logic      [W-1:0] o_cnt,
    output logic              o_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over stepping so a final step can reload in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en) begin
            cnt_d = i_down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_term = i_down ? (cnt_q == '0) : (cnt_q == '1);

endmodule
`default_nettype wire

// File: rtl/mux_serializer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_serializer_ctrl                                                  |
// | Holds a word on a 16:1 mux and steps its select to emit serial bits. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mux_serializer_ctrl
    import mux_ser_pkg::*;
#(
    parameter logic MSB_FIRST = 1'b0,
    parameter int   GAP_TICKS = 0
) (
    input wire logic          clk,
    input wire logic          rst,
    mux_serializer_ctrl_if.slave bus
);

    localparam logic [SEL_W-1:0] c_sel_start = sel_start(MSB_FIRST);
    localparam logic [3:0]       c_gap_last  = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

    ser_state_t        state_q,     state_d;
    logic [WORD_W-1:0] mux_data_q,  mux_data_d;
    logic              ser_out_q,   ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_first_q, ser_first_d;
    logic              ser_last_q,  ser_last_d;
    logic [3:0]        gap_cnt_q,   gap_cnt_d;

    logic              w_load;
    logic              w_step;
    logic              w_term;
    logic [SEL_W-1:0]  w_sel;
    logic [SEL_W-1:0]  w_bit_cnt;

    // The bit index is the select itself, mirrored when walking downward.
    assign w_bit_cnt = MSB_FIRST ? ~w_sel : w_sel;

    sel_stepper #(
        .W       (SEL_W),
        .RST_VAL (c_sel_start)
    ) u_sel_stepper (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_sel_start),
        .i_en       (w_step),
        .i_down     (MSB_FIRST),
        .o_cnt      (w_sel),
        .o_term     (w_term)
    );

    always_comb begin
        state_d     = state_q;
        mux_data_d  = mux_data_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        gap_cnt_d   = gap_cnt_q;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mux_data_d = bus.in_data;
                    w_load     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_tick) begin
                    ser_out_d   = bus.mux_f;
                    ser_valid_d = 1'b1;
                    ser_first_d = (w_bit_cnt == '0);
                    ser_last_d  = w_term;
                    w_step      = 1'b1;
                    if (w_term) begin
                        w_load    = 1'b1;
                        gap_cnt_d = 4'd0;
                        state_d   = (GAP_TICKS > 0) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                if (bus.bit_tick) begin
                    if (gap_cnt_q == c_gap_last) begin
                        gap_cnt_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mux_data_q  <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            gap_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            mux_data_q  <= mux_data_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mux_data  = mux_data_q;
    assign bus.sel       = w_sel;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_first = ser_first_q;
    assign bus.ser_last  = ser_last_q;

endmodule
`default_nettype wire

// File: doc/mux_serializer_ctrl.md
# mux_serializer_ctrl

Control stage directly upstream of the 16:1 bit multiplexer (`MUX16to1`). It accepts a 16-bit word through a valid/ready handshake and holds it stable on the mux data inputs. It then steps the mux 4-bit select through all 16 positions, one step per `bit_tick`, and registers the mux output as a framed serial bit stream. The select advances from 0 up to 15 (LSB first) by default, or from 15 down to 0 (MSB first) by parameter.

## Interface
- `MSB_FIRST`, default 0: 0 means select order 0→15; 1 means select order 15→0.
- `GAP_TICKS`, default 0: number of idle `bit_tick`s inserted after each word before `in_ready` reasserts (0 to 15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  16  word to serialize.
- `bit_tick`  in  1  single-cycle bit-rate enable.
- `mux_data`  out  16  held word, wired to the mux `i`.
- `sel`  out  4  select, wired to the mux `s`.
- `mux_f`  in  1  mux output `f` (combinational from `mux_data`/`sel`).
- `ser_out`  out  1  registered serial bit.
- `ser_valid`  out  1  one-cycle strobe: `ser_out` is new.
- `ser_first`  out  1  with `ser_valid`: first bit of the word.
- `ser_last`  out  1  with `ser_valid`: last bit of the word.

## Operation
- FSM states are IDLE, SHIFT and GAP. All outputs are registered except `in_ready`, which is high exactly when the state is IDLE.
- Reset values: state IDLE, `mux_data`=0, `sel`=0 (15 if `MSB_FIRST`), `ser_out`/`ser_valid`/`ser_first`/`ser_last`=0, bit and gap counters 0.
- IDLE: when `in_valid && in_ready`, latch `in_data` into `mux_data`, load `sel` with its start value, clear the bit counter, then go to SHIFT. `in_data` is ignored at all other times.
- SHIFT, on each `bit_tick`:
  - `ser_out` <= `mux_f` and `ser_valid` <= 1.
  - `ser_first` <= (bit counter == 0) and `ser_last` <= (bit counter == 15).
  - `sel` steps by ±1 and the bit counter increments.
  - On the tick with bit counter 15, go to GAP if `GAP_TICKS` > 0, else IDLE. `sel` is reloaded to its start value.
- SHIFT without `bit_tick`: `sel` holds and `ser_valid`=0.
- GAP: count `bit_tick`s. After `GAP_TICKS` ticks, go to IDLE.
- `mux_data` holds constant from acceptance until the next acceptance.
- `ser_valid`, `ser_first` and `ser_last` are single-cycle strobes and are 0 in every cycle without a sampled tick.
- Counter widths: bit counter 4 bits, wraps 15→0 exactly at word end. `sel` wrap-around is never visible because it is reloaded.
- Simultaneous events:
  - A tick in the acceptance cycle is ignored; the first sample needs a tick in a later cycle.
  - In the last SHIFT tick cycle, `in_ready` is still 0, so no word is accepted that cycle.
- Reset mid-word (SHIFT or GAP): abort to IDLE with reset values. The word is discarded, with no `ser_last` and no partial continuation.

## Timing
- Handshake accepted at cycle T: `sel`/`mux_data` are valid from T+1.
- The first tick at cycle t ≥ T+1 samples bit 0, and `ser_valid`/`ser_out` appear at t+1.
- Latency from a sampled tick to its `ser_out` is 1 cycle. The mux path `sel`→`mux_f` must settle within one cycle.
- Minimum word period with `GAP_TICKS`=0 and `bit_tick` always high: 17 cycles (1 accept cycle + 16 bit cycles). `in_ready` rises the cycle after the last tick.

## Structure
- Shared package `mux_ser_pkg`: `WORD_W`=16, `SEL_W`=4, state enum `ser_state_t` {IDLE, SHIFT, GAP}, and function `sel_start(msb_first)`.
- One natural sub-module, `sel_stepper`: a loadable 4-bit up/down counter with enable, returning a terminal flag. It is used for `sel`; the bit counter is derived from it.
- `MUX16to1` is instantiated beside this block by the parent, not inside it.

## Test plan
- Basic LSB-first: `in_data`=16'hA5C3, `bit_tick` always 1 → `ser_out` sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. `ser_first` on bit 1 only, `ser_last` on bit 16 only. `in_ready` low for exactly 16 cycles after acceptance.
- MSB-first (`MSB_FIRST`=1): 16'h8001 → `sel` 15→0 and `ser_out` 1, then fourteen 0s, then 1.
- Sparse ticks: `bit_tick` every 4th cycle with 16'hFFFF → 16 `ser_valid` strobes spaced 4 cycles apart. `sel` holds between ticks and `mux_data` is stable throughout.
- Back-to-back with `GAP_TICKS`=2: two words 16'h0001 and 16'h8000, `in_valid` held → second acceptance exactly 3 cycles after the first word's last tick (gap ticks + IDLE cycle). `in_data` changes while busy are ignored.
- Reset mid-word: assert `rst` after bit 7 of 16'h1234 → next cycle has all outputs at reset values and `in_ready`=1. A new word 16'h00FF then serializes correctly from bit 0.
- Handshake edge: `in_valid` high with a `bit_tick` in the acceptance cycle → no `ser_valid` at T+1, and the first sample comes from the next tick.
